// File: rtl/serial_adder_seq.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// one bit per clock over WIDTH cycles, with a start/done handshake.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q, cout_q, ovf_q, busy_q, done_q;

  logic s_bit, c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Subtraction is a + ~b + ~borrow_in in two's complement.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= sub ? ~cin : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_next;
          res_q <= {s_bit, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // c_q is the carry into the MSB here; c_next is the carry out of it.
            sum_q   <= {s_bit, res_q[WIDTH-1:1]};
            cout_q  <= c_next;
            ovf_q   <= c_q ^ c_next;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
